fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits (>=4).
REQ-002 SHALL have parameter INSTR_W, default 9, instruction word width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-006 SHALL have: reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have: halt  input  1  level; stops new fetches while high.
REQ-008 SHALL have: redirect  input  1  one-cycle pulse; flush queue and load redirect_pc.
REQ-009 SHALL have: redirect_pc  input  PC_W  new fetch address.
REQ-010 SHALL have: rom_addr  output  PC_W  instruction ROM address; equals pc combinationally.
REQ-011 SHALL have: rom_data  input  INSTR_W  ROM word for rom_addr, valid same cycle (combinational ROM).
REQ-012 SHALL have: instr_valid  output  1  queue head valid.
REQ-013 SHALL have: instr_ready  input  1  consumer accepts head when high with instr_valid.
REQ-014 SHALL have: instr  output  INSTR_W  head instruction (first-word fall-through).
REQ-015 SHALL have: instr_pc  output  PC_W  address of head instruction.
REQ-016 SHALL have: pc  output  PC_W  next address to fetch.
REQ-017 SHALL have: halted  output  1  high when halt=1 and queue empty.

Function
REQ-018 SHALL push {pc, rom_data} and set pc<=pc+1 on a rising edge when redirect=0, halt=0, and (queue not full or pop this cycle).
REQ-019 SHALL wrap pc from 2^PC_W-1 to 0 with no other side effect.
REQ-020 SHALL pop the head on a rising edge when instr_valid=1, instr_ready=1, redirect=0.
REQ-021 SHALL drive instr_valid = (occupancy != 0); instr/instr_pc = head entry, don't-care when empty.
REQ-022 SHALL make a pushed entry visible on instr_valid the cycle after its push edge (1-cycle fetch latency).
REQ-023 SHALL, on full without pop, hold pc and not push; full with pop: push and pop same edge, occupancy unchanged.
REQ-024 SHALL, on empty with push and instr_ready=1, not pop the incoming entry that edge.
REQ-025 SHALL give redirect top priority: occupancy<=0, pc<=redirect_pc, no push, no pop that edge, regardless of halt.
REQ-026 SHALL first push from redirect_pc on the edge after redirect (if halt=0); instr_valid high the following cycle.
REQ-027 SHALL hold pc and suppress pushes while halt=1; pops continue; halted rises once drained.
REQ-028 SHALL track occupancy 0..DEPTH with wrap-around read/write pointers of log2(DEPTH) bits.

Reset
REQ-029 SHALL, while reset=0, asynchronously force pc=RESET_PC, occupancy=0, pointers=0, instr_valid=0.
REQ-030 SHALL, mid-operation reset, discard all queued entries; first push on first rising edge after reset=1 (halt=0).
REQ-031 SHALL, after reset, drive rom_addr=RESET_PC and halted=halt.

Configuration
REQ-032 SHALL, with macro FETCH_PERF_CNT_EN defined, add output fetch_count (16 bits): increments per push, saturates at 0xFFFF, clears on reset only (not on redirect).
REQ-033 SHALL, without FETCH_PERF_CNT_EN, omit fetch_count port and logic; all other behaviour identical.

Verification
REQ-034 SHALL cover: reset release, halt=0, instr_ready=1 -> instr_pc 0,1,2,... one per cycle from cycle 2; instr=ROM[instr_pc].
REQ-035 SHALL cover: instr_ready=0 for 10 cycles, DEPTH=4 -> occupancy 4, pc=4 held; ready=1 -> instr_pc 0,1,2,3,4 in order, no gaps.
REQ-036 SHALL cover: redirect=1, redirect_pc=0x40 with 3 queued -> instr_valid=0 next cycle, next instr_pc=0x40, no stale entries.
REQ-037 SHALL cover: PC_W=8, pc=0xFE -> instr_pc sequence 0xFE,0xFF,0x00.
REQ-038 SHALL cover: halt=1 with 2 queued, ready=1 -> 2 pops, halted=1, pc frozen; halt=0 -> fetch resumes at frozen pc.
REQ-039 SHALL cover: FETCH_PERF_CNT_EN defined, 5 pushes, redirect, reset -> fetch_count 5, 5 after redirect, 0 after reset.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches from a combinational ROM into a
// first-word fall-through FIFO. Optional FETCH_PERF_CNT_EN adds a push counter.
module fetch_queue #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 9,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    pc,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = PC_W + INSTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_RST   = PC_W'(RESET_PC);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [ENT_W-1:0] head_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    // Handshake decode; a pop frees a slot for a same-edge push when full.
    always_comb begin
        empty_s = (count_q == {CNT_W{1'b0}});
        full_s  = (count_q == FULL_CNT);
        pop_s   = !empty_s && instr_ready && !redirect;
        push_s  = !redirect && !halt && (!full_s || pop_s);
    end

    // Next-state for pc, pointers and occupancy; redirect overrides everything.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = redirect_pc;
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_d     = pc_q + PC_W'(1);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage write: each entry carries its fetch address with the word.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {pc_q, rom_data};
        end else begin
            mem_d = mem_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= PC_RST;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        rom_addr    = pc_q;
        pc          = pc_q;
        instr_valid = !empty_s;
        instr       = head_s[INSTR_W-1:0];
        instr_pc    = head_s[ENT_W-1:INSTR_W];
        halted      = halt && empty_s;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Saturating push counter; survives redirects, cleared only by reset.
    always_comb begin
        if (push_s && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 16'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    // Counter output.
    always_comb begin
        fetch_count = fetch_count_q;
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               halt;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [PC_W-1:0]    pc;
    logic               halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]        fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [PC_W-1:0] mq[$];
    logic [PC_W-1:0] mpc;
    int              mfetch;

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] a);
        logic [PC_W-1:0] x;
        x = a ^ 8'hA5;
        return {x, a[3]};
    endfunction

    assign rom_data = rom_word(rom_addr);

    fetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .halt(halt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .pc(pc),
        .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // One clock edge: reference model applies the fetch/pop/redirect rules to the queue.
    task automatic cycle();
        bit pop_m;
        bit push_m;
        pop_m  = (mq.size() != 0) && instr_ready && !redirect;
        push_m = !redirect && !halt && ((mq.size() < DEPTH) || pop_m);
        @(posedge clk);
        if (redirect) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                mq.push_back(mpc);
                mpc = mpc + 8'd1;
                if (mfetch < 65535) mfetch++;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        mpc    = 8'd0;
        mfetch = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'd0; instr_ready = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted0 got=%b exp=0", halted); end
        halt = 1'b1;
        #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted1 got=%b exp=1", halted); end
        halt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL release_rom_addr got=%h exp=00", rom_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL release_valid got=%b exp=0", instr_valid); end
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] exp_pc;
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (instr_valid !== (i >= 1)) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, instr_valid, (i >= 1)); end
            if (i >= 1) begin
                exp_pc = 8'(i - 1);
                checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc i=%0d got=%h exp=%h", i, instr_pc, exp_pc); end
                checks++; if (instr !== rom_word(exp_pc)) begin errors++; $display("FAIL stream_instr i=%0d got=%h exp=%h", i, instr, rom_word(exp_pc)); end
            end
            cycle();
        end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) if (mq.size() < 3) cycle();
        redirect = 1'b1; redirect_pc = 8'h40; halt = 1'b1;
        cycle();
        redirect = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", instr_valid); end
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL redir_pc got=%h exp=40", pc); end
        cycle();
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid got=%b exp=1", instr_valid); end
        checks++; if (instr_pc !== 8'h40) begin errors++; $display("FAIL redir_first_pc got=%h exp=40", instr_pc); end
        checks++; if (instr !== rom_word(8'h40)) begin errors++; $display("FAIL redir_first_instr got=%h exp=%h", instr, rom_word(8'h40)); end
        cycle();
        #1;
        checks++; if (instr_pc !== 8'h41) begin errors++; $display("FAIL redir_second_pc got=%h exp=41", instr_pc); end
    endtask

    task automatic test_backpressure();
        logic [PC_W-1:0] exp_pc;
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h10;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        #1;
        checks++; if (pc !== 8'h14) begin errors++; $display("FAIL bp_pc_held got=%h exp=14", pc); end
        checks++; if (instr_pc !== 8'h10) begin errors++; $display("FAIL bp_head got=%h exp=10", instr_pc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_pc = 8'h10 + 8'(i);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid i=%0d got=%b exp=1", i, instr_valid); end
            checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL bp_drain_pc i=%0d got=%h exp=%h", i, instr_pc, exp_pc); end
            cycle();
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] exp_pc;
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
        cycle();
        redirect = 1'b0;
        cycle();
        exp_pc = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
                errors++; $display("FAIL wrap_pc i=%0d got=%b/%h exp=1/%h", i, instr_valid, instr_pc, exp_pc);
            end
            exp_pc = exp_pc + 8'd1;
            cycle();
        end
    endtask

    task automatic test_halt();
        logic [PC_W-1:0] frozen;
        instr_ready = 1'b0;
        cycle();
        halt = 1'b1; instr_ready = 1'b1;
        frozen = mpc;
        cycle();
        #1;
        checks++; if (halted !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_one_left got=%b/%b exp=0/1", halted, instr_valid); end
        cycle();
        #1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got=%b exp=1", halted); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_empty got=%b exp=0", instr_valid); end
        cycle(); cycle();
        #1;
        checks++; if (pc !== frozen) begin errors++; $display("FAIL halt_pc_frozen got=%h exp=%h", pc, frozen); end
        halt = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_release got=%b exp=0", halted); end
        cycle();
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== frozen) begin
            errors++; $display("FAIL halt_resume got=%b/%h exp=1/%h", instr_valid, instr_pc, frozen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            halt        = ($urandom_range(0, 3) == 0);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 8'($urandom);
            #1;
            checks++; if (instr_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, instr_valid, (mq.size() != 0)); end
            checks++; if (pc !== mpc || rom_addr !== mpc) begin errors++; $display("FAIL rnd_pc i=%0d got=%h/%h exp=%h", i, pc, rom_addr, mpc); end
            checks++; if (halted !== (halt && mq.size() == 0)) begin errors++; $display("FAIL rnd_halted i=%0d got=%b", i, halted); end
            if (mq.size() != 0) begin
                checks++; if (instr_pc !== mq[0]) begin errors++; $display("FAIL rnd_instr_pc i=%0d got=%h exp=%h", i, instr_pc, mq[0]); end
                checks++; if (instr !== rom_word(mq[0])) begin errors++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, instr, rom_word(mq[0])); end
            end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (fetch_count !== 16'(mfetch)) begin errors++; $display("FAIL rnd_fetch_count i=%0d got=%0d exp=%0d", i, fetch_count, mfetch); end
`endif
            cycle();
        end
        halt = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_mid_reset();
        instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
        cycle(); cycle(); cycle();
        #2 reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", instr_valid); end
        checks++; if (pc !== 8'd0 || rom_addr !== 8'd0) begin errors++; $display("FAIL mrst_pc got=%h/%h exp=00", pc, rom_addr); end
        model_reset();
        @(negedge clk);
        reset = 1'b1; instr_ready = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mrst_release_valid got=%b exp=0", instr_valid); end
        cycle();
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd0) begin
            errors++; $display("FAIL mrst_first got=%b/%h exp=1/00", instr_valid, instr_pc);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset = 1'b0; halt = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL perf_zero got=%0d exp=0", fetch_count); end
        halt = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        halt = 1'b1;
        #1;
        checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL perf_five got=%0d exp=5", fetch_count); end
        redirect = 1'b1; redirect_pc = 8'h33;
        cycle();
        redirect = 1'b0;
        #1;
        checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL perf_redirect got=%0d exp=5", fetch_count); end
        reset = 1'b0;
        #1;
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL perf_reset got=%0d exp=0", fetch_count); end
        model_reset();
        @(negedge clk);
        reset = 1'b1; halt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_redirect();
        test_backpressure();
        test_wrap();
        test_halt();
        test_random();
        test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
